// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states,
// default memory depth and the request legality check.
package mem_access_pkg;

   localparam int MEM_WORDS_DEFAULT = 41;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_BAD  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } state_e;

   // Misaligned, illegal-size or out-of-range requests never touch memory.
   function automatic logic access_error(input logic [1:0] size,
                                         input logic [11:0] addr,
                                         input int mem_words);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr[0];
         SIZE_WORD: bad = (addr[1:0] != 2'b00);
         default:   bad = 1'b1;
      endcase
      bad = bad | ({22'd0, addr[11:2]} >= 32'(mem_words));
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of pipeline request/response and memory-side signals of the unit.
// master = surrounding pipeline + memory, slave = the access unit.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [9:0]  mem_address;
   logic [31:0] mem_data_in;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_data_out;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output mem_data_out,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  mem_address, mem_data_in, mem_write, mem_read
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  mem_data_out,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output mem_address, mem_data_in, mem_write, mem_read
   );
endinterface

// File: rtl/byte_lane_align.sv
// Little-endian lane handling: extracts/extends sub-word load data and merges
// sub-word store data into a full memory word.
module byte_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [1:0]  lane,
   input  logic [31:0] word_in,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the addressed lane(s), then extend for loads or splice for stores.
   always_comb begin
      byte_s      = word_in[{lane, 3'b000} +: 8];
      half_s      = lane[1] ? word_in[31:16] : word_in[15:0];
      load_data   = 32'h0000_0000;
      merged_word = word_in;
      case (size)
         SIZE_BYTE: begin
            load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
         end
         SIZE_HALF: begin
            load_data = {{16{sign_ext & half_s[15]}}, half_s};
            if (lane[1]) begin
               merged_word[31:16] = store_data[15:0];
            end else begin
               merged_word[15:0] = store_data[15:0];
            end
         end
         SIZE_WORD: begin
            load_data   = word_in;
            merged_word = store_data;
         end
         default: begin
            load_data   = 32'h0000_0000;
            merged_word = word_in;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit_core.sv
// Request FSM: IDLE -> (READ) -> (WRITE) -> RESP, with sub-word stores done
// as read-modify-write. All memory and response outputs are registered.
module mem_access_unit_core
   import mem_access_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT
)
(
   input logic              clock,
   input logic              reset_n,
   mem_access_unit_if.slave bus
);

   state_e      state_r;
   logic        write_r;
   logic        signed_r;
   logic [1:0]  size_r;
   logic [1:0]  lane_r;
   logic [31:0] wdata_r;
   logic [31:0] load_data_s;
   logic [31:0] merged_s;
   logic        req_error_s;

   assign bus.req_ready = (state_r == IDLE);
   assign req_error_s   = access_error(bus.req_size, bus.req_addr, MEM_WORDS);

   byte_lane_align u_align (
      .size        (size_r),
      .sign_ext    (signed_r),
      .lane        (lane_r),
      .word_in     (bus.mem_data_out),
      .store_data  (wdata_r),
      .load_data   (load_data_s),
      .merged_word (merged_s)
   );

   // FSM with registered memory strobes and response outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= IDLE;
         write_r         <= 1'b0;
         signed_r        <= 1'b0;
         size_r          <= 2'b00;
         lane_r          <= 2'b00;
         wdata_r         <= 32'h0000_0000;
         bus.resp_valid  <= 1'b0;
         bus.resp_error  <= 1'b0;
         bus.resp_rdata  <= 32'h0000_0000;
         bus.mem_address <= 10'd0;
         bus.mem_data_in <= 32'h0000_0000;
         bus.mem_write   <= 1'b0;
         bus.mem_read    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid) begin
                  write_r         <= bus.req_write;
                  signed_r        <= bus.req_signed;
                  size_r          <= bus.req_size;
                  lane_r          <= bus.req_addr[1:0];
                  wdata_r         <= bus.req_wdata;
                  bus.mem_address <= bus.req_addr[11:2];
                  if (req_error_s) begin
                     state_r        <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_error <= 1'b1;
                     bus.resp_rdata <= 32'h0000_0000;
                  end else if (bus.req_write && (bus.req_size == SIZE_WORD)) begin
                     state_r         <= WRITE;
                     bus.mem_write   <= 1'b1;
                     bus.mem_data_in <= bus.req_wdata;
                  end else begin
                     state_r      <= READ;
                     bus.mem_read <= 1'b1;
                  end
               end
            end
            READ: begin
               bus.mem_read <= 1'b0;
               if (write_r) begin
                  state_r         <= WRITE;
                  bus.mem_write   <= 1'b1;
                  bus.mem_data_in <= merged_s;
               end else begin
                  state_r        <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_error <= 1'b0;
                  bus.resp_rdata <= load_data_s;
               end
            end
            WRITE: begin
               state_r        <= RESP;
               bus.mem_write  <= 1'b0;
               bus.resp_valid <= 1'b1;
               bus.resp_error <= 1'b0;
               bus.resp_rdata <= 32'h0000_0000;
            end
            RESP: begin
               state_r        <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.resp_error <= 1'b0;
               bus.resp_rdata <= 32'h0000_0000;
            end
            default: begin
               state_r        <= IDLE;
               bus.mem_write  <= 1'b0;
               bus.mem_read   <= 1'b0;
               bus.resp_valid <= 1'b0;
               bus.resp_error <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between pipeline and word-addressed data memory; flat ports
// are gathered into the bundle interface consumed by the FSM core.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT
)
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [11:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [9:0]  mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_data_out
);

   mem_access_unit_if bus ();

   assign bus.req_valid    = req_valid;
   assign bus.req_write    = req_write;
   assign bus.req_size     = req_size;
   assign bus.req_signed   = req_signed;
   assign bus.req_addr     = req_addr;
   assign bus.req_wdata    = req_wdata;
   assign bus.mem_data_out = mem_data_out;

   assign req_ready   = bus.req_ready;
   assign resp_valid  = bus.resp_valid;
   assign resp_rdata  = bus.resp_rdata;
   assign resp_error  = bus.resp_error;
   assign mem_address = bus.mem_address;
   assign mem_data_in = bus.mem_data_in;
   assign mem_write   = bus.mem_write;
   assign mem_read    = bus.mem_read;

   mem_access_unit_core #(.MEM_WORDS(MEM_WORDS)) u_core (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: behavioural memory, scoreboard queue of expected
// responses, one task per scenario.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic [3:0]  lat;
      logic [1:0]  reads;
      logic [1:0]  writes;
      logic        both;
      logic [9:0]  raddr;
      logic [31:0] wword;
      logic [9:0]  waddr;
   } txn_t;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] mem [0:1023];
   logic        poke_en   = 1'b0;
   logic [9:0]  poke_addr = 10'd0;
   logic [31:0] poke_data = 32'h0;
   int          checks = 0;
   int          errors = 0;
   txn_t        exp_q[$];

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (bus.req_valid),
      .req_ready    (bus.req_ready),
      .req_write    (bus.req_write),
      .req_size     (bus.req_size),
      .req_signed   (bus.req_signed),
      .req_addr     (bus.req_addr),
      .req_wdata    (bus.req_wdata),
      .resp_valid   (bus.resp_valid),
      .resp_rdata   (bus.resp_rdata),
      .resp_error   (bus.resp_error),
      .mem_address  (bus.mem_address),
      .mem_data_in  (bus.mem_data_in),
      .mem_write    (bus.mem_write),
      .mem_read     (bus.mem_read),
      .mem_data_out (bus.mem_data_out)
   );

   always #5 clock = ~clock;

   assign bus.mem_data_out = bus.mem_read ? mem[bus.mem_address] : 32'h0;

   always @(posedge clock) begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_in;
   end

   function automatic txn_t mk(input logic [31:0] rdata, input logic err, input int lat,
                               input int rd, input int wr, input int raddr,
                               input logic [31:0] wword, input int waddr);
      txn_t t;
      t.rdata = rdata; t.error = err; t.lat = 4'(lat);
      t.reads = 2'(rd); t.writes = 2'(wr); t.both = 1'b0;
      t.raddr = 10'(raddr); t.wword = wword; t.waddr = 10'(waddr);
      return t;
   endfunction

   function automatic string fmt(input txn_t t);
      return $sformatf("rdata=%h err=%b lat=%0d rd=%0d wr=%0d both=%b raddr=%0d wword=%h waddr=%0d",
                       t.rdata, t.error, t.lat, t.reads, t.writes, t.both, t.raddr, t.wword, t.waddr);
   endfunction

   task automatic poke(input logic [9:0] a, input logic [31:0] d);
      @(negedge clock);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge clock);
      poke_en = 1'b0;
   endtask

   // Drives one request and records everything seen until its response.
   task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [11:0] addr, input logic [31:0] wd, output txn_t obs);
      obs = '0;
      @(negedge clock);
      bus.req_write = wr; bus.req_size = sz; bus.req_signed = sg;
      bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
      @(negedge clock);
      bus.req_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (bus.mem_read) begin obs.reads = obs.reads + 2'd1; obs.raddr = bus.mem_address; end
         if (bus.mem_write) begin
            obs.writes = obs.writes + 2'd1; obs.wword = bus.mem_data_in; obs.waddr = bus.mem_address;
         end
         if (bus.mem_read && bus.mem_write) obs.both = 1'b1;
         if (bus.resp_valid) begin
            obs.rdata = bus.resp_rdata; obs.error = bus.resp_error; obs.lat = 4'(c);
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = 12'h000; bus.req_wdata = 32'h0;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_write, bus.mem_read} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy/rv/re/mw/mr=%b expected 10000",
                  {bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_write, bus.mem_read});
      end
      checks++;
      if ({bus.resp_rdata, bus.mem_address, bus.mem_data_in} !== 74'd0) begin
         errors++;
         $display("FAIL reset_data: got rdata=%h addr=%h din=%h expected all zero",
                  bus.resp_rdata, bus.mem_address, bus.mem_data_in);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL post_reset: got rdy/rv=%b expected 10", {bus.req_ready, bus.resp_valid});
      end
   endtask

   task automatic test_word_store();
      txn_t o, e;
      exp_q.push_back(mk(32'h0, 1'b0, 2, 0, 1, 0, 32'hDEADBEEF, 4));
      send(1'b1, SIZE_WORD, 1'b0, 12'h010, 32'hDEADBEEF, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL word_store: got %s expected %s", fmt(o), fmt(e)); end
      checks++;
      if (mem[4] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL word_store_mem: got %h expected deadbeef", mem[4]);
      end
   endtask

   task automatic test_loads();
      typedef struct packed {logic [1:0] sz; logic sg; logic [11:0] addr; logic [31:0] rdata;} ld_t;
      ld_t  tbl [8];
      txn_t o, e;
      tbl = '{'{2'b00, 1'b1, 12'h012, 32'hFFFFFFFF}, '{2'b00, 1'b0, 12'h013, 32'h00000080},
              '{2'b01, 1'b1, 12'h012, 32'hFFFF80FF}, '{2'b01, 1'b0, 12'h010, 32'h00007F01},
              '{2'b00, 1'b1, 12'h011, 32'h0000007F}, '{2'b00, 1'b0, 12'h012, 32'h000000FF},
              '{2'b10, 1'b1, 12'h010, 32'h80FF7F01}, '{2'b01, 1'b0, 12'h012, 32'h000080FF}};
      poke(10'd4, 32'h80FF7F01);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(mk(tbl[i].rdata, 1'b0, 2, 1, 0, 4, 32'h0, 0));
         send(1'b0, tbl[i].sz, tbl[i].sg, tbl[i].addr, 32'h0, o);
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL load_%0d: got %s expected %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_rmw_store();
      txn_t o, e;
      poke(10'd4, 32'h11223344);
      exp_q.push_back(mk(32'h0, 1'b0, 3, 1, 1, 4, 32'h1122AA44, 4));
      send(1'b1, SIZE_BYTE, 1'b0, 12'h011, 32'h123456AA, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rmw_byte: got %s expected %s", fmt(o), fmt(e)); end
      exp_q.push_back(mk(32'h0, 1'b0, 3, 1, 1, 4, 32'hBEEFAA44, 4));
      send(1'b1, SIZE_HALF, 1'b1, 12'h012, 32'h0000BEEF, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rmw_half: got %s expected %s", fmt(o), fmt(e)); end
      exp_q.push_back(mk(32'hBEEFAA44, 1'b0, 2, 1, 0, 4, 32'h0, 0));
      send(1'b0, SIZE_WORD, 1'b0, 12'h010, 32'h0, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rmw_readback: got %s expected %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_errors();
      typedef struct packed {logic wr; logic [1:0] sz; logic [11:0] addr; logic err;} er_t;
      er_t  tbl [8];
      txn_t o, e;
      tbl = '{'{1'b0, 2'b10, 12'h002, 1'b1}, '{1'b0, 2'b01, 12'h001, 1'b1},
              '{1'b0, 2'b11, 12'h010, 1'b1}, '{1'b0, 2'b10, 12'h0A4, 1'b1},
              '{1'b0, 2'b00, 12'h0A4, 1'b1}, '{1'b1, 2'b10, 12'h0A4, 1'b1},
              '{1'b1, 2'b01, 12'h013, 1'b1}, '{1'b0, 2'b10, 12'h0A0, 1'b0}};
      poke(10'd40, 32'h0A0A0A0A);
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].err) exp_q.push_back(mk(32'h0, 1'b1, 1, 0, 0, 0, 32'h0, 0));
         else exp_q.push_back(mk(32'h0A0A0A0A, 1'b0, 2, 1, 0, 40, 32'h0, 0));
         send(tbl[i].wr, tbl[i].sz, 1'b1, tbl[i].addr, 32'hFFFFFFFF, o);
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL error_%0d: got %s expected %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_reset_abort();
      int bad;
      bad = 0;
      poke(10'd5, 32'hCAFEF00D);
      @(negedge clock);
      bus.req_write = 1'b1; bus.req_size = SIZE_HALF; bus.req_signed = 1'b0;
      bus.req_addr = 12'h014; bus.req_wdata = 32'h00001234; bus.req_valid = 1'b1;
      @(negedge clock);
      bus.req_valid = 1'b0;
      checks++;
      if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL abort_in_read: got mem_read=%b expected 1", bus.mem_read); end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready, bus.resp_valid, bus.mem_read, bus.mem_write} !== 4'b1000) begin
         errors++;
         $display("FAIL abort_immediate: got rdy/rv/mr/mw=%b expected 1000",
                  {bus.req_ready, bus.resp_valid, bus.mem_read, bus.mem_write});
      end
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (bus.mem_write || bus.resp_valid || !bus.req_ready) bad++;
         @(negedge clock);
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
      checks++;
      if (mem[5] !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_mem: got %h expected cafef00d", mem[5]); end
   endtask

   task automatic test_back_to_back();
      typedef struct packed {logic wr; logic [1:0] sz; logic [11:0] addr; logic [31:0] wd; logic [31:0] rdata; logic err;} bb_t;
      bb_t  tbl [4];
      txn_t e;
      int   idx, resp_cnt, ready_bad;
      logic pending;
      tbl = '{'{1'b0, 2'b10, 12'h010, 32'h0, 32'hBEEFAA44, 1'b0},
              '{1'b1, 2'b10, 12'h014, 32'h00000055, 32'h0, 1'b0},
              '{1'b0, 2'b00, 12'h0A4, 32'h0, 32'h0, 1'b1},
              '{1'b1, 2'b00, 12'h015, 32'h00000066, 32'h0, 1'b0}};
      idx = 0; resp_cnt = 0; ready_bad = 0;
      @(negedge clock);
      bus.req_write = tbl[0].wr; bus.req_size = tbl[0].sz; bus.req_signed = 1'b0;
      bus.req_addr = tbl[0].addr; bus.req_wdata = tbl[0].wd; bus.req_valid = 1'b1;
      for (int c = 0; c < 80; c++) begin
         if (bus.resp_valid) begin
            resp_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra_resp: got response %0d expected none", resp_cnt);
            end else begin
               e = exp_q.pop_front();
               if ({bus.resp_rdata, bus.resp_error} !== {e.rdata, e.error}) begin
                  errors++;
                  $display("FAIL b2b_resp_%0d: got rdata=%h err=%b expected rdata=%h err=%b",
                           resp_cnt, bus.resp_rdata, bus.resp_error, e.rdata, e.error);
               end
            end
         end
         if ((bus.resp_valid || bus.mem_read || bus.mem_write) && bus.req_ready) ready_bad++;
         pending = bus.req_valid && bus.req_ready;
         if (pending) exp_q.push_back(mk(tbl[idx].rdata, tbl[idx].err, 0, 0, 0, 0, 32'h0, 0));
         if (resp_cnt == 4 && !bus.req_valid) break;
         @(negedge clock);
         if (pending) begin
            idx++;
            if (idx < 4) begin
               bus.req_write = tbl[idx].wr; bus.req_size = tbl[idx].sz;
               bus.req_addr = tbl[idx].addr; bus.req_wdata = tbl[idx].wd;
            end else begin
               bus.req_valid = 1'b0;
            end
         end
      end
      bus.req_valid = 1'b0;
      checks++;
      if (idx !== 4 || resp_cnt !== 4) begin
         errors++; $display("FAIL b2b_count: got accepts=%0d resps=%0d expected 4 and 4", idx, resp_cnt);
      end
      checks++;
      if (ready_bad !== 0) begin errors++; $display("FAIL b2b_ready: got %0d busy cycles with ready expected 0", ready_bad); end
      checks++;
      if (mem[5] !== 32'h00006655) begin errors++; $display("FAIL b2b_mem: got %h expected 00006655", mem[5]); end
      checks++;
      if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d pending expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_loads();
      test_rmw_store();
      test_errors();
      test_reset_abort();
      test_back_to_back();
      repeat (2) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 41: number of 32-bit words in the downstream data memory.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-008 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port req_addr  input  12  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  aligned and extended load data; 0 for stores.
REQ-013 SHALL have port resp_error  output  1  request rejected; qualified by resp_valid.
REQ-014 SHALL have port mem_address  output  10  word index to memory (req_addr[11:2]).
REQ-015 SHALL have port mem_data_in  output  32  write word to memory.
REQ-016 SHALL have port mem_write  output  1  memory write strobe.
REQ-017 SHALL have port mem_read  output  1  memory read strobe.
REQ-018 SHALL have port mem_data_out  input  32  memory read word; valid in the cycle mem_read is high.

Function
REQ-019 SHALL implement states IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, and latch all req_* fields.
REQ-021 SHALL classify the request as an error when: req_size = 11; halfword with addr[0] = 1; word with addr[1:0] != 00; or word index >= MEM_WORDS.
REQ-022 Error path SHALL go IDLE->RESP with no mem_read or mem_write, then respond with resp_error = 1 and resp_rdata = 0.
REQ-023 Aligned word store SHALL go IDLE->WRITE->RESP with mem_write = 1 for exactly the WRITE cycle, giving resp_valid 2 cycles after acceptance.
REQ-024 Load SHALL go IDLE->READ->RESP; mem_read = 1 in READ; mem_data_out sampled at the end of READ; resp_valid 2 cycles after acceptance.
REQ-025 Byte/halfword store SHALL go IDLE->READ->WRITE->RESP (read-modify-write), replacing only the addressed lanes; resp_valid 3 cycles after acceptance.
REQ-026 Lane mapping SHALL be little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; halfword at addr[1] selects bits [31:16] or [15:0].
REQ-027 Sub-word loads SHALL be sign-extended when req_signed = 1, else zero-extended; word loads SHALL ignore req_signed.
REQ-028 resp_valid SHALL be high for exactly one cycle (RESP); there is no response back-pressure; RESP SHALL return to IDLE.
REQ-029 mem_address, mem_data_in, mem_write, mem_read SHALL be registered outputs; mem_write and mem_read SHALL be 0 outside WRITE/READ, and never both 1.
REQ-030 req_valid while req_ready = 0 SHALL be ignored (request held by the pipeline).

Reset
REQ-031 reset_n low SHALL immediately force IDLE, resp_valid = 0, resp_error = 0, resp_rdata = 0, mem_write = 0, mem_read = 0, mem_address = 0, mem_data_in = 0; req_ready = 1.
REQ-032 Reset asserted mid-request SHALL abandon it with no response; a read-modify-write aborted before WRITE SHALL not write memory.

Structure
REQ-033 Package mem_access_pkg SHALL hold the size encodings, the state enum, and the MEM_WORDS default.
REQ-034 Lane extract/extend and lane merge SHALL be a combinational sub-module byte_lane_align.

Verification
REQ-035 Word store addr 0x010, data 0xDEADBEEF -> mem_write one cycle, mem_address 4, mem_data_in 0xDEADBEEF; resp_valid 2 cycles after accept.
REQ-036 Memory word 4 = 0x80FF7F01; lb addr 0x012 signed -> resp_rdata 0xFFFFFFFF; lbu addr 0x013 -> 0x00000080; lh addr 0x012 signed -> 0xFFFF80FF.
REQ-037 Memory word 4 = 0x11223344; sb addr 0x011 data 0xAA -> read then write 0x1122AA44; resp_valid 3 cycles after accept.
REQ-038 Word load addr 0x002, halfword addr 0x001, size 11, and word addr 0x0A4 (index 41) -> resp_error = 1, no mem strobes.
REQ-039 reset_n pulsed low during READ of a halfword store -> no mem_write, no resp_valid, req_ready = 1 immediately.
REQ-040 Back-to-back req_valid held high -> req_ready low in non-IDLE states; each request accepted exactly once.
